// File: rtl/shared_block_rotate_sequencer_if.sv
// Handshake and data bundle for the 2-share byte-rotation sequencer.
// SHARE_REFRESH_EN adds the rnd mask input.
interface shared_block_rotate_sequencer_if #(
  parameter int CNT_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_share0;
  logic [63:0]      in_share1;
  logic [CNT_W-1:0] in_steps;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_share0;
  logic [63:0]      out_share1;
  logic             busy;
`ifdef SHARE_REFRESH_EN
  logic [63:0]      rnd;
`endif

  modport master (
`ifdef SHARE_REFRESH_EN
    output rnd,
`endif
    output in_valid,
    output in_share0,
    output in_share1,
    output in_steps,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_share0,
    input  out_share1,
    input  busy
  );

  modport slave (
`ifdef SHARE_REFRESH_EN
    input  rnd,
`endif
    input  in_valid,
    input  in_share0,
    input  in_share1,
    input  in_steps,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_share0,
    output out_share1,
    output busy
  );
endinterface

// File: rtl/shared_block_rotate_sequencer.sv
// Sequences per-word 8-bit left rotations on a 2-share 64-bit state.
// Optional SHARE_REFRESH_EN re-masks both shares with rnd on completion.
module shared_block_rotate_sequencer #(
  parameter int CNT_W = 2
) (
  input logic                            clk,
  input logic                            rst,
  shared_block_rotate_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      s0;
  logic [63:0]      s1;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [63:0]      mask_acc;
  logic [63:0]      mask_q;

  // one step: each 32-bit word rotates left by one byte
  function automatic logic [63:0] rot_step(
    input logic [63:0] v
  );
    return {v[55:32], v[63:56],
            v[23:0],  v[31:24]};
  endfunction

`ifdef SHARE_REFRESH_EN
  logic [63:0] rnd_q;

  // mask is captured with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_q <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      rnd_q <= bus.rnd;
    end
  end

  assign mask_acc = bus.rnd;
  assign mask_q   = rnd_q;
`else
  assign mask_acc = '0;
  assign mask_q   = '0;
`endif

  // control FSM with registered handshake flags and state regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      s0          <= '0;
      s1          <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cnt        <= bus.in_steps;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.in_steps != '0) begin
              s0    <= bus.in_share0;
              s1    <= bus.in_share1;
              state <= SHIFT;
            end else begin
              s0          <= bus.in_share0 ^ mask_acc;
              s1          <= bus.in_share1 ^ mask_acc;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            s0          <= rot_step(s0) ^ mask_q;
            s1          <= rot_step(s1) ^ mask_q;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            s0 <= rot_step(s0);
            s1 <= rot_step(s1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.out_share0 = s0;
  assign bus.out_share1 = s1;

endmodule

// File: tb/tb_shared_block_rotate_sequencer.sv
// Directed bench for shared_block_rotate_sequencer.
// Define SHARE_REFRESH_EN to also exercise the mask refresh.
module tb_shared_block_rotate_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  shared_block_rotate_sequencer_if #(.CNT_W(2)) bus();

  shared_block_rotate_sequencer #(.CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag,
                      input int obs,
                      input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // reference rotation by shifts, n bytes per word
  function automatic logic [63:0] ref_rot(
    input logic [63:0] v, input int n);
    logic [31:0] hi, lo;
    hi = v[63:32];
    lo = v[31:0];
    if (n != 0) begin
      hi = (hi << (8*n)) | (hi >> (32-8*n));
      lo = (lo << (8*n)) | (lo >> (32-8*n));
    end
    return {hi, lo};
  endfunction

  // accept one op, wait for out_valid, check, then drain
  task automatic run(input string tag,
                     input logic [63:0] a0,
                     input logic [63:0] a1,
                     input logic [1:0] st,
                     input logic [63:0] e0,
                     input logic [63:0] e1,
                     input int elat);
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_share0 = a0;
    bus.in_share1 = a1;
    bus.in_steps  = st;
    bus.out_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.in_valid  = 1'b0;
      bus.in_share0 = '0;
      bus.in_share1 = '0;
      bus.in_steps  = '0;
    end while (!bus.out_valid && lat < 10);
    chki({tag, "_lat"}, lat, elat);
    chk({tag, "_s0"}, bus.out_share0, e0);
    chk({tag, "_s1"}, bus.out_share1, e1);
    chk1({tag, "_rdy"}, bus.in_ready, 1'b0);
    chk1({tag, "_busy"}, bus.busy, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk1({tag, "_ov0"}, bus.out_valid, 1'b0);
    chk1({tag, "_rdy1"}, bus.in_ready, 1'b1);
  endtask

  localparam logic [63:0] S0 = 64'h01234567_89ABCDEF;
  localparam logic [63:0] S1 = 64'hFFFF0000_0000FFFF;

  initial begin
    logic [63:0] a0, a1, x;
    logic [1:0]  st;
    int lat, rdy_hi, cyc, exp_cyc;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_share0 = '0;
    bus.in_share1 = '0;
    bus.in_steps  = '0;
    bus.out_ready = 1'b0;
`ifdef SHARE_REFRESH_EN
    bus.rnd = '0;
`endif
    @(negedge clk);
    chk1("rst_rdy", bus.in_ready, 1'b1);
    chk1("rst_ov", bus.out_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk("rst_o0", bus.out_share0, 64'h0);
    chk("rst_o1", bus.out_share1, 64'h0);
    rst = 1'b0;

    run("t2", S0, S1, 2'd1,
        64'h23456701_ABCDEF89,
        64'hFF0000FF_00FFFF00, 2);
    chk("t2_hold", bus.out_share0,
        64'h23456701_ABCDEF89);
    run("t3_0", S0, S1, 2'd0,
        64'h01234567_89ABCDEF, S1, 1);
    run("t3_2", S0, S1, 2'd2,
        64'h45670123_CDEF89AB,
        64'h0000FFFF_FFFF0000, 3);
    run("t3_3", S0, S1, 2'd3,
        64'h67012345_EF89ABCD,
        64'h00FFFF00_FF0000FF, 4);

    // reset while in SHIFT
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_share0 = S1;
    bus.in_share1 = S0;
    bus.in_steps  = 2'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk1("t1_busy_pre", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("t1_rdy", bus.in_ready, 1'b1);
    chk1("t1_ov", bus.out_valid, 1'b0);
    chk1("t1_busy", bus.busy, 1'b0);
    chk("t1_o0", bus.out_share0, 64'h0);
    chk("t1_o1", bus.out_share1, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk1("t1_no_res", bus.out_valid, 1'b0);
    chk1("t1_idle", bus.in_ready, 1'b1);

    // backpressure in DONE
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_share0 = S0;
    bus.in_share1 = S1;
    bus.in_steps  = 2'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk1("t4_ov", bus.out_valid, 1'b1);
      chk1("t4_rdy", bus.in_ready, 1'b0);
      chk("t4_o0", bus.out_share0,
          64'h23456701_ABCDEF89);
      chk("t4_o1", bus.out_share1,
          64'hFF0000FF_00FFFF00);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk1("t4_ov0", bus.out_valid, 1'b0);
    chk1("t4_rdy1", bus.in_ready, 1'b1);
    chk1("t4_busy0", bus.busy, 1'b0);

    // in_valid held high, random steps
    bus.in_valid = 1'b1;
    cyc = 0;
    exp_cyc = 0;
    for (int t = 0; t < 8; t++) begin
      st = 2'($urandom_range(0, 3));
      a0 = {$urandom, $urandom};
      a1 = {$urandom, $urandom};
      bus.in_share0 = a0;
      bus.in_share1 = a1;
      bus.in_steps  = st;
      exp_cyc += int'(st) + 2;
      lat = 0;
      rdy_hi = 0;
      do begin
        @(negedge clk);
        lat++;
        if (bus.in_ready) rdy_hi++;
      end while (!bus.out_valid && lat < 10);
      chki("t5_lat", lat, int'(st) + 1);
      chki("t5_rdy", rdy_hi, 0);
      x = ref_rot(a0 ^ a1, int'(st));
      chk("t5_xor",
          bus.out_share0 ^ bus.out_share1, x);
      @(negedge clk);
      chk1("t5_idle", bus.in_ready, 1'b1);
      cyc += lat + 1;
    end
    chki("t5_cyc", cyc, exp_cyc);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

`ifdef SHARE_REFRESH_EN
    bus.rnd = 64'hA5A5A5A5_5A5A5A5A;
    run("t6", S0, S1, 2'd1,
        64'h23456701_ABCDEF89 ^ 64'hA5A5A5A5_5A5A5A5A,
        64'h5AA5A55A_5AA5A55A, 2);
    chk("t6_xor",
        bus.out_share0 ^ bus.out_share1,
        64'h23456701_ABCDEF89 ^ 64'hFF0000FF_00FFFF00);
    bus.rnd = '0;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
